cp_sym_sched: RTL and testbench

- Symbol-level controller for the transmit cyclic-prefix stage.
- Owns a two-bank ping-pong symbol RAM: NFFT-sample symbols from the IFFT are written into one bank while the other bank is read out as CP (last LCP samples) followed by the full symbol.
- Sequences one frame of NSYM symbols per start pulse and flags output underrun.
- Sits between the IFFT output and the DAC-side sample stream; the RAM is external, a 1-cycle-read dual-port RAM.

---
 rtl/cp_sym_sched_if.sv | 49 ++++
 rtl/cp_sym_sched.sv | 202 ++++++++++++++++++++
 tb/tb_cp_sym_sched.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp_sym_sched_if.sv
// Sample/RAM bus of the cyclic-prefix symbol scheduler: IFFT sample
// handshake, ping-pong RAM write/read strobes and the output stream markers.
interface cp_sym_sched_if #(
  parameter int AW = 6
);

  logic          IN_VLD_I;
  logic          IN_RDY_O;
  logic          WR_EN_O;
  logic          WR_BANK_O;
  logic [AW-1:0] WR_ADDR_O;
  logic          RD_EN_O;
  logic          RD_BANK_O;
  logic [AW-1:0] RD_ADDR_O;
  logic          OUT_VLD_O;
  logic          SOS_O;
  logic          EOFRM_O;

  // Scheduler side: accepts IFFT samples, drives the RAM and stream markers.
  modport master (
    input  IN_VLD_I,
    output IN_RDY_O,
    output WR_EN_O,
    output WR_BANK_O,
    output WR_ADDR_O,
    output RD_EN_O,
    output RD_BANK_O,
    output RD_ADDR_O,
    output OUT_VLD_O,
    output SOS_O,
    output EOFRM_O
  );

  // Environment side: IFFT source, RAM and DAC-side consumer.
  modport slave (
    output IN_VLD_I,
    input  IN_RDY_O,
    input  WR_EN_O,
    input  WR_BANK_O,
    input  WR_ADDR_O,
    input  RD_EN_O,
    input  RD_BANK_O,
    input  RD_ADDR_O,
    input  OUT_VLD_O,
    input  SOS_O,
    input  EOFRM_O
  );

endinterface

// File: rtl/cp_sym_sched.sv
// Transmit cyclic-prefix symbol scheduler. Writes IFFT symbols into one bank
// of an external ping-pong RAM while the other bank is replayed as the last
// LCP samples (the prefix) followed by the whole symbol.
module cp_sym_sched #(
  parameter int NFFT = 64,
  parameter int LCP  = 16,
  parameter int AW   = 6
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  FRM_START_I,
  input  logic [7:0]            NSYM_I,
  cp_sym_sched_if.master        bus,
  output logic                  BUSY_O,
  output logic                  FRM_DONE_O,
  output logic                  UNDERRUN_O
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_CP   = 2'd1;
  localparam logic [1:0] R_BODY = 2'd2;

  localparam logic [AW:0]   CNT_BODY_LAST = (AW+1)'(NFFT - 1);
  localparam logic [AW:0]   CNT_CP_LAST   = (AW+1)'(LCP - 1);
  localparam logic [AW-1:0] CP_BASE       = AW'(NFFT - LCP);

  logic          busy_q,     busy_d;
  logic [7:0]    nsym_q,     nsym_d;
  logic          wr_bank_q,  wr_bank_d;
  logic          rd_bank_q,  rd_bank_d;
  logic [1:0]    full_q,     full_d;
  logic [AW:0]   wr_cnt_q,   wr_cnt_d;
  logic [AW:0]   rd_cnt_q,   rd_cnt_d;
  logic [7:0]    wr_sym_q,   wr_sym_d;
  logic [7:0]    rd_sym_q,   rd_sym_d;
  logic [1:0]    rstate_q,   rstate_d;
  logic          out_vld_q,  out_vld_d;
  logic          sos_q,      sos_d;
  logic          eofrm_q,    eofrm_d;
  logic          frm_done_q, frm_done_d;
  logic          underrun_q, underrun_d;

  logic          in_rdy;
  logic          wr_acc;
  logic          rd_active;
  logic          cp_last;
  logic          body_last;
  logic          frm_last;
  logic          start_acc;
  logic          empty_done;
  logic [AW-1:0] rd_addr;

  // Handshake and end-of-phase decodes shared by the next-state logic and ports.
  always_comb begin
    in_rdy     = busy_q & ~full_q[wr_bank_q] & (wr_sym_q < nsym_q);
    wr_acc     = bus.IN_VLD_I & in_rdy;
    rd_active  = (rstate_q != R_IDLE);
    cp_last    = (rstate_q == R_CP) && (rd_cnt_q == CNT_CP_LAST);
    body_last  = (rstate_q == R_BODY) && (rd_cnt_q == CNT_BODY_LAST);
    frm_last   = body_last && ((rd_sym_q + 8'd1) == nsym_q);
    start_acc  = FRM_START_I & ~busy_q;
    empty_done = busy_q & (nsym_q == 8'd0);
    rd_addr    = '0;
    if (rstate_q == R_CP) begin
      rd_addr = CP_BASE + rd_cnt_q[AW-1:0];
    end else if (rstate_q == R_BODY) begin
      rd_addr = rd_cnt_q[AW-1:0];
    end
  end

  // Next state: write counters, read FSM, bank full flags and frame control.
  always_comb begin
    busy_d     = busy_q;
    nsym_d     = nsym_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_sym_d   = wr_sym_q;
    rd_sym_d   = rd_sym_q;
    rstate_d   = rstate_q;
    underrun_d = underrun_q;
    out_vld_d  = rd_active;
    sos_d      = (rstate_q == R_CP) && (rd_cnt_q == '0);
    eofrm_d    = frm_last;
    frm_done_d = frm_last | empty_done;

    if (wr_acc) begin
      if (wr_cnt_q == CNT_BODY_LAST) begin
        wr_cnt_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_sym_d          = wr_sym_q + 8'd1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    case (rstate_q)
      R_IDLE: begin
        if (busy_q && full_q[rd_bank_q]) begin
          rstate_d = R_CP;
          rd_cnt_d = '0;
        end
      end
      R_CP: begin
        if (cp_last) begin
          rstate_d = R_BODY;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      R_BODY: begin
        if (body_last) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          rd_sym_d          = rd_sym_q + 8'd1;
          rd_cnt_d          = '0;
          if (frm_last) begin
            rstate_d = R_IDLE;
          end else if (full_q[~rd_bank_q]) begin
            rstate_d = R_CP;
          end else begin
            rstate_d   = R_IDLE;
            underrun_d = 1'b1;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    if (frm_done_q || empty_done) begin
      busy_d = 1'b0;
    end
    if (start_acc) begin
      busy_d     = 1'b1;
      nsym_d     = NSYM_I;
      underrun_d = 1'b0;
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      wr_sym_d   = '0;
      rd_sym_d   = '0;
      full_d     = '0;
    end
  end

  // State registers with synchronous reset; reset abandons any frame in flight.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      busy_q     <= 1'b0;
      nsym_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_sym_q   <= '0;
      rd_sym_q   <= '0;
      rstate_q   <= R_IDLE;
      out_vld_q  <= 1'b0;
      sos_q      <= 1'b0;
      eofrm_q    <= 1'b0;
      frm_done_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      nsym_q     <= nsym_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_sym_q   <= wr_sym_d;
      rd_sym_q   <= rd_sym_d;
      rstate_q   <= rstate_d;
      out_vld_q  <= out_vld_d;
      sos_q      <= sos_d;
      eofrm_q    <= eofrm_d;
      frm_done_q <= frm_done_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.IN_RDY_O  = in_rdy;
  assign bus.WR_EN_O   = wr_acc;
  assign bus.WR_BANK_O = wr_bank_q;
  assign bus.WR_ADDR_O = wr_cnt_q[AW-1:0];
  assign bus.RD_EN_O   = rd_active;
  assign bus.RD_BANK_O = rd_bank_q;
  assign bus.RD_ADDR_O = rd_addr;
  assign bus.OUT_VLD_O = out_vld_q;
  assign bus.SOS_O     = sos_q;
  assign bus.EOFRM_O   = eofrm_q;
  assign BUSY_O        = busy_q;
  assign FRM_DONE_O    = frm_done_q;
  assign UNDERRUN_O    = underrun_q;

endmodule

// File: tb/tb_cp_sym_sched.sv
// Self-checking bench for cp_sym_sched: a symbol-level model (counts of
// symbols written/read, beat position in the symbol) predicts every output on
// every cycle; directed frames pin the model with hand-computed values.
module tb_cp_sym_sched;

  localparam int NFFT = 64;
  localparam int LCP  = 16;
  localparam int AW   = 6;
  localparam int FB   = NFFT + LCP;

  logic       clk = 1'b0;
  logic       rst;
  logic       frm_start;
  logic [7:0] nsym_in;
  logic       busy;
  logic       frm_done;
  logic       underrun;

  cp_sym_sched_if #(.AW(AW)) bus ();

  cp_sym_sched #(.NFFT(NFFT), .LCP(LCP), .AW(AW)) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .FRM_START_I (frm_start),
    .NSYM_I      (nsym_in),
    .bus         (bus),
    .BUSY_O      (busy),
    .FRM_DONE_O  (frm_done),
    .UNDERRUN_O  (underrun)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: frame bookkeeping in symbol/beat terms.
  int m_busy, m_nsym, m_underrun;
  int m_wr_samp, m_wr_sym, m_rd_sym;
  int m_reading, m_beat, m_bank_base;
  int m_out_vld, m_sos, m_eofrm, m_done;

  // Per-frame observations of the DUT for directed checks.
  int         mon_beats, mon_first_out, mon_last_out, mon_sos_beat, mon_eofrm_beat, mon_eofrm_cnt;
  int         mon_rd_cnt, mon_first_rd_cyc, mon_first_rd_addr, mon_first_rd_bank;
  int         mon_wr_cnt, mon_last_wr_cyc, mon_rdy_low, mon_busy_rise, mon_done_cnt, mon_done_cyc;
  int         mon_nsym;
  logic [7:0] mon_sos_banks;

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  function automatic int expRdy();
    return (m_busy != 0 && (m_wr_sym - m_rd_sym) < 2 && m_wr_sym < m_nsym) ? 1 : 0;
  endfunction

  function automatic int expRdAddr();
    if (m_reading == 0) return 0;
    return (m_beat < LCP) ? (NFFT - LCP + m_beat) : (m_beat - LCP);
  endfunction

  task automatic checkOutput();
    int rdy;
    rdy = expRdy();
    checkVal("busy",     int'(busy),          m_busy);
    checkVal("underrun", int'(underrun),      m_underrun);
    checkVal("frm_done", int'(frm_done),      m_done);
    checkVal("out_vld",  int'(bus.OUT_VLD_O), m_out_vld);
    checkVal("sos",      int'(bus.SOS_O),     m_sos);
    checkVal("eofrm",    int'(bus.EOFRM_O),   m_eofrm);
    checkVal("in_rdy",   int'(bus.IN_RDY_O),  rdy);
    checkVal("wr_en",    int'(bus.WR_EN_O),   (bus.IN_VLD_I && rdy != 0) ? 1 : 0);
    checkVal("wr_bank",  int'(bus.WR_BANK_O), (m_bank_base + m_wr_sym) % 2);
    checkVal("wr_addr",  int'(bus.WR_ADDR_O), m_wr_samp);
    checkVal("rd_en",    int'(bus.RD_EN_O),   m_reading);
    checkVal("rd_bank",  int'(bus.RD_BANK_O), (m_bank_base + m_rd_sym) % 2);
    checkVal("rd_addr",  int'(bus.RD_ADDR_O), expRdAddr());
  endtask

  task automatic modelUpdate();
    int rdy, acc, last, old_busy;
    int n_out_vld, n_sos, n_eofrm, n_done;
    if (rst) begin
      m_busy = 0; m_nsym = 0; m_underrun = 0; m_wr_samp = 0; m_wr_sym = 0;
      m_rd_sym = 0; m_reading = 0; m_beat = 0; m_bank_base = 0;
      m_out_vld = 0; m_sos = 0; m_eofrm = 0; m_done = 0;
      return;
    end
    rdy       = expRdy();
    acc       = (bus.IN_VLD_I && rdy != 0) ? 1 : 0;
    last      = (m_reading != 0 && m_beat == FB - 1) ? 1 : 0;
    n_out_vld = m_reading;
    n_sos     = (m_reading != 0 && m_beat == 0) ? 1 : 0;
    n_eofrm   = (last != 0 && m_rd_sym + 1 == m_nsym) ? 1 : 0;
    n_done    = (n_eofrm != 0 || (m_busy != 0 && m_nsym == 0)) ? 1 : 0;
    if (m_reading != 0) begin
      if (last == 0) begin
        m_beat++;
      end else begin
        if (m_rd_sym + 1 == m_nsym) m_reading = 0;
        else if (m_wr_sym >= m_rd_sym + 2) m_beat = 0;
        else begin
          m_reading  = 0;
          m_underrun = 1;
        end
        m_rd_sym++;
      end
    end else if (m_busy != 0 && m_wr_sym > m_rd_sym) begin
      m_reading = 1;
      m_beat    = 0;
    end
    if (acc != 0) begin
      if (m_wr_samp == NFFT - 1) begin
        m_wr_samp = 0;
        m_wr_sym++;
      end else begin
        m_wr_samp++;
      end
    end
    old_busy = m_busy;
    if (m_done != 0 || (old_busy != 0 && m_nsym == 0)) m_busy = 0;
    if (frm_start && old_busy == 0) begin
      m_bank_base = (m_bank_base + m_nsym) % 2;
      m_nsym      = int'(nsym_in);
      m_busy      = 1;
      m_underrun  = 0;
      m_wr_samp   = 0;
      m_wr_sym    = 0;
      m_rd_sym    = 0;
      m_reading   = 0;
      m_beat      = 0;
    end
    m_out_vld = n_out_vld;
    m_sos     = n_sos;
    m_eofrm   = n_eofrm;
    m_done    = n_done;
  endtask

  task automatic clearMon(input int n);
    mon_beats = 0; mon_first_out = -1; mon_last_out = -1; mon_sos_beat = 0;
    mon_eofrm_beat = 0; mon_eofrm_cnt = 0; mon_rd_cnt = 0; mon_first_rd_cyc = -1;
    mon_first_rd_addr = -1; mon_first_rd_bank = -1; mon_wr_cnt = 0; mon_last_wr_cyc = -1;
    mon_rdy_low = 0; mon_busy_rise = -1; mon_done_cnt = 0; mon_done_cyc = -1;
    mon_sos_banks = '0; mon_nsym = n;
  endtask

  task automatic monitorTick();
    if (busy && bus.IN_VLD_I && !bus.IN_RDY_O && mon_wr_cnt < mon_nsym * NFFT) mon_rdy_low++;
    if (bus.OUT_VLD_O) begin
      mon_beats++;
      if (mon_first_out < 0) mon_first_out = cyc;
      mon_last_out = cyc;
      if (bus.SOS_O) begin
        if (mon_sos_beat == 0) mon_sos_beat = mon_beats;
        mon_sos_banks = {mon_sos_banks[6:0], bus.RD_BANK_O};
      end
      if (bus.EOFRM_O) begin
        mon_eofrm_beat = mon_beats;
        mon_eofrm_cnt++;
      end
    end
    if (bus.RD_EN_O) begin
      mon_rd_cnt++;
      if (mon_first_rd_cyc < 0) begin
        mon_first_rd_cyc  = cyc;
        mon_first_rd_addr = int'(bus.RD_ADDR_O);
        mon_first_rd_bank = int'(bus.RD_BANK_O);
      end
    end
    if (bus.WR_EN_O) begin
      mon_wr_cnt++;
      mon_last_wr_cyc = cyc;
    end
    if (busy && mon_busy_rise < 0) mon_busy_rise = cyc;
    if (frm_done) begin
      mon_done_cnt++;
      if (mon_done_cyc < 0) mon_done_cyc = cyc;
    end
  endtask

  // One clock: compare mid-cycle, advance the model on the edge, then return
  // just after the edge so the caller can drive the next cycle's inputs.
  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    monitorTick();
    @(posedge clk);
    modelUpdate();
    cyc++;
    #1;
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    bus.IN_VLD_I = 1'b0;
    frm_start = 1'b0;
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  // mode 0: IN_VLD_I held high; 1: random IN_VLD_I; 2: 40-cycle gap during
  // the second symbol; 3: held high plus a stray FRM_START_I mid-frame.
  task automatic applyStimulus(input int n, input int mode);
    int rel;
    clearMon(n);
    frm_start    = 1'b1;
    nsym_in      = 8'(n);
    bus.IN_VLD_I = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    stepCycle();
    frm_start = 1'b0;
    rel = 1;
    while (mon_done_cnt == 0 && rel < 3000) begin
      case (mode)
        1:       bus.IN_VLD_I = ($urandom_range(0, 3) != 0);
        2:       bus.IN_VLD_I = !(rel >= 80 && rel < 120);
        default: bus.IN_VLD_I = 1'b1;
      endcase
      if (mode == 3 && rel == 100) begin
        frm_start = 1'b1;
        nsym_in   = 8'd7;
      end else begin
        frm_start = 1'b0;
      end
      stepCycle();
      rel++;
    end
    frm_start = 1'b0;
    if (mon_done_cnt == 0) checkVal("frame_timeout_done_seen", 0, 1);
    bus.IN_VLD_I = 1'b0;
    repeat (3) stepCycle();
  endtask

  initial begin
    int guard;
    rst          = 1'b1;
    frm_start    = 1'b0;
    nsym_in      = 8'd0;
    bus.IN_VLD_I = 1'b0;
    @(posedge clk);
    modelUpdate();
    cyc++;
    #1;
    stepCycle();
    checkVal("reset_busy",  int'(busy),          0);
    checkVal("reset_rd_en", int'(bus.RD_EN_O),   0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] single symbol, continuous input");
    applyStimulus(1, 0);
    checkVal("t1_wr_to_rd_latency", mon_first_rd_cyc - mon_last_wr_cyc, 2);
    checkVal("t1_first_rd_addr",    mon_first_rd_addr, 48);
    checkVal("t1_first_rd_bank",    mon_first_rd_bank, 0);
    checkVal("t1_beats",            mon_beats, 80);
    checkVal("t1_sos_beat",         mon_sos_beat, 1);
    checkVal("t1_eofrm_beat",       mon_eofrm_beat, 80);
    checkVal("t1_done_cnt",         mon_done_cnt, 1);
    checkVal("t1_done_with_eofrm",  mon_done_cyc, mon_last_out);

    $display("[TB] four symbols, continuous input");
    resetPulse();
    applyStimulus(4, 0);
    checkVal("t2_beats",      mon_beats, 320);
    checkVal("t2_contiguous", mon_last_out - mon_first_out + 1, 320);
    checkVal("t2_rdy_dropped", (mon_rdy_low > 0) ? 1 : 0, 1);
    checkVal("t2_sos_banks",  int'(mon_sos_banks), 5);
    checkVal("t2_underrun",   int'(underrun), 0);

    $display("[TB] three symbols with input gap");
    applyStimulus(3, 2);
    checkVal("t3_beats",        mon_beats, 240);
    checkVal("t3_output_gap",   (mon_last_out - mon_first_out + 1 > 240) ? 1 : 0, 1);
    checkVal("t3_underrun",     int'(underrun), 1);
    repeat (10) stepCycle();
    checkVal("t3_underrun_held", int'(underrun), 1);

    $display("[TB] empty frame");
    applyStimulus(0, 0);
    checkVal("t4_done_after_busy", mon_done_cyc - mon_busy_rise, 1);
    checkVal("t4_no_writes",       mon_wr_cnt, 0);
    checkVal("t4_no_reads",        mon_rd_cnt, 0);
    checkVal("t4_no_eofrm",        mon_eofrm_cnt, 0);
    checkVal("t4_underrun_clear",  int'(underrun), 0);

    $display("[TB] start pulse ignored mid-frame");
    applyStimulus(2, 3);
    checkVal("t5_beats", mon_beats, 160);

    $display("[TB] reset during symbol body");
    clearMon(2);
    frm_start    = 1'b1;
    nsym_in      = 8'd2;
    bus.IN_VLD_I = 1'b1;
    stepCycle();
    frm_start = 1'b0;
    guard = 0;
    while (!(mon_first_rd_cyc >= 0 && cyc - mon_first_rd_cyc > LCP + 4) && guard < 500) begin
      stepCycle();
      guard++;
    end
    checkVal("t6_reached_body", (guard < 500) ? 1 : 0, 1);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    bus.IN_VLD_I = 1'b0;
    checkVal("t6_rst_rd_en",   int'(bus.RD_EN_O),   0);
    checkVal("t6_rst_busy",    int'(busy),          0);
    checkVal("t6_rst_out_vld", int'(bus.OUT_VLD_O), 0);
    repeat (3) stepCycle();
    applyStimulus(1, 0);
    checkVal("t6_first_rd_addr", mon_first_rd_addr, 48);
    checkVal("t6_first_rd_bank", mon_first_rd_bank, 0);
    checkVal("t6_beats",         mon_beats, 80);

    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      applyStimulus(int'($urandom_range(1, 4)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
